argmax_frame_packer: RTL
========================

Name: argmax_frame_packer

Overview:
- Transmit-side front end for the argmax/max-select stage of the CNN classifier.
- Collects NUMINPUT serial neuron scores from the final layer, one per handshake beat, into one packed vector.
- Presents the vector with a single-cycle valid pulse.
- Holds off the next frame until the downstream max stage signals completion, so a frame is never overwritten mid-scan.

Parameters:
- NUMINPUT, 10, number of scores per frame (≥2)
- INPUTWIDTH, 16, bits per score
- WAIT_DONE_EN, 1, 1 = block until done_in after each frame; 0 = return to collecting right after the pulse

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  INPUTWIDTH  serial score
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  packer can accept a beat this cycle
- out_data  output  NUMINPUT*INPUTWIDTH  packed frame; score k at bits [k*INPUTWIDTH +: INPUTWIDTH]
- out_valid  output  1  one-cycle pulse, frame on out_data is complete
- done_in  input  1  pulse from the max stage's result-valid output
- frame_cnt  output  16  frames issued, wraps at 16'hFFFF→0

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state=COLLECT, beat index=0, buffer=0
  - out_data=0, out_valid=0, in_ready=1, frame_cnt=0
  - A partially collected frame is discarded.
- All outputs are registered. in_ready is 1 exactly when state=COLLECT.
- COLLECT:
  - A beat is accepted on a rising edge with in_valid&&in_ready.
  - in_data is written to buffer slice [idx*INPUTWIDTH +: INPUTWIDTH]; idx increments. idx width is $clog2(NUMINPUT).
  - in_valid low: no change, idle cycles are allowed between beats.
  - Beat with idx==NUMINPUT-1: buffer is copied to out_data in the same edge, out_valid=1, in_ready=0, idx=0, frame_cnt+1, state→FIRE.
- FIRE:
  - Lasts exactly one cycle with out_valid=1; next edge out_valid=0.
  - State→WAIT_DONE if WAIT_DONE_EN=1, else →COLLECT with in_ready=1.
- WAIT_DONE:
  - in_ready=0. On done_in=1, state→COLLECT and in_ready=1 the following cycle.
- done_in handling:
  - Sampled only in WAIT_DONE. done_in in COLLECT or FIRE is ignored, not remembered.
  - When WAIT_DONE_EN=0, done_in is ignored entirely.
- Latency: out_valid is high in the cycle after the edge accepting the last beat. Minimum frame period is NUMINPUT+1 cycles (WAIT_DONE_EN=0); otherwise NUMINPUT+2+downstream scan time.
- out_data holds its value from the FIRE edge until the next FIRE edge. It never changes while downstream is scanning.
- in_valid asserted while in_ready=0: the beat is not consumed. The source must hold it (valid/ready semantics); in_data may change only after acceptance.
- Scores are unsigned and passed unmodified, with no arithmetic or saturation.
- frame_cnt increments once per out_valid pulse, modulo 2^16.

Decomposition:
- Shared package cnn_pkg:
  - typedef enum logic [1:0] {COLLECT, FIRE, WAIT_DONE} packer_state_t
  - localparam helper for index width $clog2(NUMINPUT)
- No sub-module. Single always_ff for state/index/buffer plus continuous assignment of in_ready. Estimated 120–180 RTL lines.

Test Plan:
- Reset, then 10 beats 16'd5,3,9,1,0,7,2,8,4,6 back-to-back (NUMINPUT=10, W=16) → out_valid pulse exactly 1 cycle, on the cycle after beat 10. out_data[15:0]=5, out_data[47:32]=9, out_data[159:144]=6. frame_cnt=1. in_ready=0 afterwards.
- WAIT_DONE_EN=1: hold in_valid=1 with next-frame data after FIRE, with done_in asserted 14 cycles later → no beat accepted before done_in. in_ready=1 the cycle after done_in. First new beat lands at slice 0. Previous out_data is unchanged until the second FIRE.
- Random in_valid gaps (50% duty) over 3 frames → each frame packs in order. Exactly 3 out_valid pulses; frame_cnt=3.
- Assert rst for 1 cycle asynchronously after beat 6 of a frame → outputs go to reset values immediately. The next 10 beats form a clean frame with beat 1 at slice 0.
- done_in pulsed during COLLECT (beat 3) and during FIRE → ignored; the packer still waits in WAIT_DONE for a later done_in.
- WAIT_DONE_EN=0, continuous in_valid → out_valid every 11 cycles. Force frame_cnt to 16'hFFFF, run one frame → wraps to 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN classifier back end.
//   packer_state_t : state encoding of the argmax frame packer
//   idx_width()    : width of a beat index that counts 0..n-1 (never below 1 bit)
package cnn_pkg;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        FIRE      = 2'd1,
        WAIT_DONE = 2'd2
    } packer_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_frame_packer.sv
// Argmax frame packer: gathers NUMINPUT serial scores from the last CNN layer
// into one packed frame, issues it with a one-cycle valid pulse and, when
// WAIT_DONE_EN is set, holds off the next frame until the max stage reports done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// COLLECT   | accepting score beats, in_ready=1
// FIRE      | out_valid=1 for exactly this cycle, out_data holds the frame
// WAIT_DONE | max stage scanning out_data; wait for done_in
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_data    : serial score, in_valid/in_ready handshake
//   out_data   : packed frame, score k at [k*INPUTWIDTH +: INPUTWIDTH]
//   out_valid  : one-cycle pulse, frame complete
//   done_in    : max stage result-valid pulse, only sampled in WAIT_DONE
//   frame_cnt  : frames issued, wraps modulo 2^16
module argmax_frame_packer
    import cnn_pkg::*;
#(
    parameter int NUMINPUT     = 10,
    parameter int INPUTWIDTH   = 16,
    parameter bit WAIT_DONE_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INPUTWIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUMINPUT*INPUTWIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           done_in,
    output logic [15:0]                    frame_cnt
);

    localparam int FRAME_W = NUMINPUT * INPUTWIDTH;
    localparam int IDX_W   = idx_width(NUMINPUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMINPUT - 1);

    packer_state_t      state;
    packer_state_t      state_next;
    logic [IDX_W-1:0]   idx;
    logic [FRAME_W-1:0] buffer;
    logic [FRAME_W-1:0] buffer_next;
    logic               accept;
    logic               last_beat;

    assign in_ready  = (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (idx == LAST_IDX);

    // Buffer with the current beat merged in; on the last beat this is also
    // the frame copied to out_data, so the final score lands in the same edge.
    always_comb begin
        buffer_next = buffer;
        buffer_next[int'(idx) * INPUTWIDTH +: INPUTWIDTH] = in_data;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT:   if (last_beat) state_next = FIRE;
            FIRE:      state_next = WAIT_DONE_EN ? WAIT_DONE : COLLECT;
            WAIT_DONE: if (done_in) state_next = COLLECT;
            default:   state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= '0;
            buffer    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_next;
            out_valid <= last_beat;
            if (accept) begin
                buffer <= buffer_next;
                idx    <= last_beat ? '0 : idx + IDX_W'(1);
            end
            // out_data only moves here, so it is stable while downstream scans.
            if (last_beat) begin
                out_data  <= buffer_next;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
